// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus between pipeline control and the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 2
);
  localparam int NUM_REGS = 2**ADDR_W;
  logic [ADDR_W-1:0]   rs1_addr, rs2_addr;
  logic [WORD_W-1:0]   rs1_data, rs2_data;
  logic                rs1_used, rs2_used;
  logic                wb_write;
  logic [ADDR_W-1:0]   wb_addr;
  logic [WORD_W-1:0]   wb_data;
  logic                issue;
  logic [ADDR_W-1:0]   issue_dest;
  logic                issue_writes;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] busy;
  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used, wb_write, wb_addr, wb_data,
           issue, issue_dest, issue_writes, flush,
    input  rs1_data, rs2_data, stall, busy
  );
  modport slave (
    input  rs1_addr, rs2_addr, rs1_used, rs2_used, wb_write, wb_addr, wb_data,
           issue, issue_dest, issue_writes, flush,
    output rs1_data, rs2_data, stall, busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with writeback bypass and per-register pending-write counters
module regfile_scoreboard #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [WORD_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic [CNT_W-1:0]  c1, c2, cd;
  logic              wb1, wb2, wbd, haz1, haz2, sat, issue_eff;
  assign wb1 = bus.wb_write && bus.wb_addr == bus.rs1_addr;
  assign wb2 = bus.wb_write && bus.wb_addr == bus.rs2_addr;
  assign wbd = bus.wb_write && bus.wb_addr == bus.issue_dest;
  assign c1  = cnt_q[bus.rs1_addr];
  assign c2  = cnt_q[bus.rs2_addr];
  assign cd  = cnt_q[bus.issue_dest];
  // A source is still pending unless its single outstanding write retires this cycle
  assign haz1 = bus.rs1_used && (c1 > ONE || (c1 == ONE && !wb1));
  assign haz2 = bus.rs2_used && (c2 > ONE || (c2 == ONE && !wb2));
  // A full counter can only accept a new issue when a writeback frees a slot this cycle
  assign sat       = bus.issue && bus.issue_writes && cd == MAX && !wbd;
  assign bus.stall = haz1 || haz2 || sat;
  assign issue_eff = bus.issue && bus.issue_writes && !bus.stall;
  assign bus.rs1_data = wb1 ? bus.wb_data : regs_q[bus.rs1_addr];
  assign bus.rs2_data = wb2 ? bus.wb_data : regs_q[bus.rs2_addr];
  // Counter next-state (issue and retire on the same register cancel) and busy flags from current state
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = bus.flush ? '0
        : (issue_eff && bus.issue_dest == ADDR_W'(i) && bus.wb_write && bus.wb_addr == ADDR_W'(i)) ? cnt_q[i]
        : (issue_eff && bus.issue_dest == ADDR_W'(i)) ? cnt_q[i] + ONE
        : (bus.wb_write && bus.wb_addr == ADDR_W'(i) && cnt_q[i] != '0) ? cnt_q[i] - ONE
        : cnt_q[i];
      bus.busy[i] = cnt_q[i] != '0;
    end
  end
  // Register array and counters update together; reset clears both immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (bus.wb_write) regs_q[bus.wb_addr] <= bus.wb_data;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus random traffic against an array-based scoreboard model
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;
  logic [15:0] m_regs [4];
  int          m_cnt  [4];

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WORD_W(16), .ADDR_W(2)) bus ();
  regfile_scoreboard #(.WORD_W(16), .ADDR_W(2), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  // Pending writes still outstanding after this cycle's writeback retires one
  function automatic int ecnt(int a);
    return m_cnt[a] - ((bus.wb_write && int'(bus.wb_addr) == a && m_cnt[a] > 0) ? 1 : 0);
  endfunction

  function automatic logic m_stall();
    logic h1, h2, s;
    h1 = bus.rs1_used && ecnt(int'(bus.rs1_addr)) > 0;
    h2 = bus.rs2_used && ecnt(int'(bus.rs2_addr)) > 0;
    s  = bus.issue && bus.issue_writes && m_cnt[bus.issue_dest] == 3 &&
         !(bus.wb_write && bus.wb_addr == bus.issue_dest);
    return h1 || h2 || s;
  endfunction

  function automatic logic [15:0] m_read(logic [1:0] a);
    return (bus.wb_write && bus.wb_addr == a) ? bus.wb_data : m_regs[a];
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = m_cnt[i] != 0;
    return b;
  endfunction

  task automatic model_step();
    logic ie;
    int   d, w;
    ie = bus.issue && bus.issue_writes && !m_stall();
    d  = int'(bus.issue_dest);
    w  = int'(bus.wb_addr);
    if (bus.flush) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (!(ie && bus.wb_write && d == w)) begin
      if (ie) m_cnt[d]++;
      if (bus.wb_write && m_cnt[w] > 0) m_cnt[w]--;
    end
    if (bus.wb_write) m_regs[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    chk({tag, "_rs1"},   32'(bus.rs1_data), 32'(m_read(bus.rs1_addr)));
    chk({tag, "_rs2"},   32'(bus.rs2_data), 32'(m_read(bus.rs2_addr)));
    chk({tag, "_stall"}, 32'(bus.stall),    32'(m_stall()));
    chk({tag, "_busy"},  32'(bus.busy),     32'(m_busy()));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rs1_used = 0; bus.rs2_used = 0;
    bus.wb_write = 0;  bus.wb_addr = '0;  bus.wb_data = '0;
    bus.issue = 0;     bus.issue_dest = '0; bus.issue_writes = 0; bus.flush = 0;
  endtask

  task automatic issue_to(logic [1:0] d);
    clr();
    bus.issue = 1; bus.issue_dest = d; bus.issue_writes = 1;
  endtask

  task automatic wb_to(logic [1:0] a, logic [15:0] v);
    clr();
    bus.wb_write = 1; bus.wb_addr = a; bus.wb_data = v;
  endtask

  initial begin
    reset_n = 0;
    clr();
    model_reset();
    #2;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_rs1", 32'(bus.rs1_data), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_stall", 32'(bus.stall), 32'h0);

    wb_to(2, 16'h1234);
    bus.rs1_addr = 2;
    #1 chk("bypass", 32'(bus.rs1_data), 32'h1234);
    cycle("wr_r2");
    clr();
    bus.rs1_addr = 2;
    #1 chk("stored", 32'(bus.rs1_data), 32'h1234);
    cycle("rd_r2");

    issue_to(1);
    #1 chk("iss1_stall", 32'(bus.stall), 32'h0);
    cycle("iss1");
    clr();
    bus.rs1_addr = 1; bus.rs1_used = 1;
    #1 chk("raw_stall", 32'(bus.stall), 32'h1);
    chk("raw_busy1", 32'(bus.busy[1]), 32'h1);
    cycle("raw");
    wb_to(1, 16'h00AA);
    bus.rs1_addr = 1; bus.rs1_used = 1;
    #1 chk("wb1_stall", 32'(bus.stall), 32'h0);
    chk("wb1_data", 32'(bus.rs1_data), 32'h00AA);
    cycle("wb1");

    for (int i = 0; i < 3; i++) begin
      issue_to(3);
      cycle("fill3");
    end
    clr();
    #1 chk("sat_busy", 32'(bus.busy), 32'h8);
    issue_to(3);
    #1 chk("sat_stall", 32'(bus.stall), 32'h1);
    cycle("sat");
    for (int i = 0; i < 2; i++) begin
      wb_to(3, 16'(i));
      cycle("drain3");
    end
    clr();
    #1 chk("drain2_busy3", 32'(bus.busy[3]), 32'h1);
    wb_to(3, 16'h0033);
    cycle("drain3_last");
    clr();
    #1 chk("drained_busy3", 32'(bus.busy[3]), 32'h0);

    issue_to(0);
    cycle("iss0");
    issue_to(0);
    bus.wb_write = 1; bus.wb_addr = 0; bus.wb_data = 16'h0BEE;
    bus.rs2_addr = 0; bus.rs2_used = 0;
    #1 chk("same_stall", 32'(bus.stall), 32'h0);
    cycle("same0");
    clr();
    #1 chk("same_busy", 32'(bus.busy), 32'h1);
    wb_to(0, 16'h0C0C);
    cycle("clr0");

    issue_to(1);
    cycle("f_iss1");
    issue_to(3);
    cycle("f_iss3");
    clr();
    #1 chk("pre_flush_busy", 32'(bus.busy), 32'hA);
    issue_to(2);
    bus.flush = 1;
    cycle("flush");
    clr();
    #1 chk("flush_busy", 32'(bus.busy), 32'h0);

    issue_to(1);
    cycle("r_iss1");
    issue_to(3);
    cycle("r_iss3");
    clr();
    #1 chk("pre_rst_busy", 32'(bus.busy), 32'hA);
    #2 reset_n = 0;
    model_reset();
    #1 chk("async_busy", 32'(bus.busy), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.rs1_addr = 2'(a);
      #1 chk("async_reg", 32'(bus.rs1_data), 32'h0);
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      bus.rs1_addr     = 2'($urandom);
      bus.rs2_addr     = 2'($urandom);
      bus.rs1_used     = 1'($urandom);
      bus.rs2_used     = 1'($urandom);
      bus.wb_write     = $urandom_range(0, 2) == 0;
      bus.wb_addr      = 2'($urandom);
      bus.wb_data      = 16'($urandom);
      bus.issue        = 1'($urandom);
      bus.issue_dest   = 2'($urandom);
      bus.issue_writes = $urandom_range(0, 3) != 0;
      bus.flush        = $urandom_range(0, 15) == 0;
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
